// File: rtl/generic_bus_ram_responder_pkg.sv
// generic_bus_ram_responder_pkg: shared types and defaults for the bus RAM responder
package gbus_resp_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef logic [31:0] word_t;
  typedef logic [3:0] byte_en_t;
  localparam word_t ERR_RDATA_DEF = 32'hBAD1_BAD1;
endpackage

// File: rtl/generic_bus_ram_responder_if.sv
// generic_bus_if: request/response bus between an initiator and a memory responder
interface generic_bus_if;
  import gbus_resp_pkg::*;
  word_t addr;
  word_t wdata;
  word_t rdata;
  byte_en_t byte_en;
  logic ren;
  logic wen;
  logic busy;
  logic err;
  modport master(output addr, wdata, byte_en, ren, wen, input rdata, busy, err);
  modport slave(input addr, wdata, byte_en, ren, wen, output rdata, busy, err);
endinterface

// File: rtl/generic_bus_ram_responder_ram_array.sv
// gbus_ram_array: single-port word RAM with byte write enables and registered read
module gbus_ram_array import gbus_resp_pkg::*; #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  byte_en_t      be,
  input  word_t         wd,
  output word_t         q
);
  word_t mem [DEPTH_WORDS];
  // storage is never reset; only enabled byte lanes are written
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  // read register clears on reset and holds between reads
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (re) q <= mem[idx];
endmodule

// File: rtl/generic_bus_ram_responder.sv
// generic_bus_ram_responder: byte-enabled RAM responder with programmable wait states
module generic_bus_ram_responder import gbus_resp_pkg::*; #(
  parameter word_t BASE_ADDR   = 32'h8000_0000,
  parameter int    DEPTH_WORDS = 4096,
  parameter int    WAIT_STATES = 0,
  parameter word_t ERR_RDATA   = ERR_RDATA_DEF
) (
  input logic clk,
  input logic rst,
  generic_bus_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  word_t addr_q, wdata_q, ram_q;
  byte_en_t be_q;
  logic wr_q, both_q, rd_miss_q, err_q;
  logic req, hit, enter_resp, rd_fire, we;
  logic [AW-1:0] idx;
  assign req = bus.ren | bus.wen;
  assign hit = {1'b0, addr_q} >= {1'b0, BASE_ADDR} && {1'b0, addr_q} < {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  assign idx = AW'((addr_q - BASE_ADDR) >> 2);
  assign enter_resp = state == WAIT && req && cnt == 4'd0;
  assign rd_fire = enter_resp && !wr_q;
  assign we = state == RESP && wr_q && hit && !rst;
  assign bus.busy = state != RESP;
  assign bus.err = err_q;
  assign bus.rdata = rd_miss_q ? ERR_RDATA : ram_q;
  // next state: a withdrawn request in WAIT returns to IDLE without completing
  always_comb begin
    state_n = state == IDLE ? (req ? WAIT : IDLE) :
              state == WAIT ? (!req ? IDLE : cnt == 4'd0 ? RESP : WAIT) : IDLE;
    cnt_n = state == IDLE ? (req ? 4'(WAIT_STATES) : cnt) :
            (state == WAIT && cnt != 4'd0) ? cnt - 4'd1 : cnt;
  end
  // state and wait counter register
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  // request capture; later changes on the bus are ignored until the next IDLE
  always_ff @(posedge clk)
    if (state == IDLE && req) begin
      addr_q <= bus.addr;
      wdata_q <= bus.wdata;
      be_q <= bus.byte_en;
      wr_q <= bus.wen;
      both_q <= bus.ren & bus.wen;
    end
  // response status: err pulses for the RESP cycle, read-miss selects the error pattern
  always_ff @(posedge clk)
    if (rst) begin
      err_q <= 1'b0;
      rd_miss_q <= 1'b0;
    end else begin
      err_q <= enter_resp && (!hit || both_q);
      if (rd_fire) rd_miss_q <= !hit;
    end
  gbus_ram_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk(clk),
    .rst(rst),
    .re(rd_fire && hit),
    .we(we),
    .idx(idx),
    .be(be_q),
    .wd(wdata_q),
    .q(ram_q)
  );
endmodule

// File: tb/tb_generic_bus_ram_responder.sv
// tb_generic_bus_ram_responder: randomized self-checking bench against a word-map model
module tb_generic_bus_ram_responder;
  import gbus_resp_pkg::*;
  localparam word_t BASE = 32'h8000_0000;
  localparam word_t ERRV = 32'hBAD1_BAD1;
  localparam int D0 = 4096;
  localparam int D1 = 16;
  localparam int W1 = 3;
  logic clk = 0;
  logic rst = 1;
  int total = 0;
  int bad = 0;
  word_t m0 [int];
  word_t m1 [int];
  generic_bus_if b0();
  generic_bus_if b1();
  generic_bus_ram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(D0), .WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  generic_bus_ram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(D1), .WAIT_STATES(W1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  always #5 clk = ~clk;

  function automatic bit in_rng(word_t a, int depth);
    return longint'(a) >= longint'(BASE) && longint'(a) < longint'(BASE) + 4 * longint'(depth);
  endfunction

  function automatic int widx(word_t a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  task automatic mwrite(input bit s, input word_t a, input word_t d, input byte_en_t be);
    word_t o;
    int i;
    if (!in_rng(a, s ? D1 : D0)) return;
    i = widx(a);
    o = s ? (m1.exists(i) ? m1[i] : '0) : (m0.exists(i) ? m0[i] : '0);
    for (int k = 0; k < 4; k++) if (be[k]) o[8*k +: 8] = d[8*k +: 8];
    if (s) m1[i] = o; else m0[i] = o;
  endtask

  function automatic word_t mread(bit s, word_t a);
    if (!in_rng(a, s ? D1 : D0)) return ERRV;
    return s ? m1[widx(a)] : m0[widx(a)];
  endfunction

  task automatic drive(input bit s, input logic r, input logic w, input word_t a, input word_t d, input byte_en_t be);
    if (s) begin
      b1.ren = r; b1.wen = w; b1.addr = a; b1.wdata = d; b1.byte_en = be;
    end else begin
      b0.ren = r; b0.wen = w; b0.addr = a; b0.wdata = d; b0.byte_en = be;
    end
  endtask

  task automatic acc(input bit s, input logic r, input logic w, input word_t a, input word_t d, input byte_en_t be,
                     output int lat, output word_t rd, output logic er);
    lat = -1;
    rd = '0;
    er = 1'b0;
    drive(s, r, w, a, d, be);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (!(s ? b1.busy : b0.busy)) begin
        lat = i;
        rd = s ? b1.rdata : b0.rdata;
        er = s ? b1.err : b0.err;
        break;
      end
    end
    drive(s, 1'b0, 1'b0, a, d, be);
    @(negedge clk);
  endtask

  task automatic test_reset;
    int lat;
    drive(0, 1'b1, 1'b0, BASE, '0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (b0.busy !== 1'b1) begin bad++; $display("FAIL reset_busy cyc%0d got %b want 1", i, b0.busy); end
      total++; if (b0.rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata cyc%0d got %h want 0", i, b0.rdata); end
      total++; if (b0.err !== 1'b0) begin bad++; $display("FAIL reset_err cyc%0d got %b want 0", i, b0.err); end
    end
    rst = 0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!b0.busy) begin lat = i; break; end
    end
    total++; if (lat !== 2) begin bad++; $display("FAIL reset_first_latency got %0d want 2", lat); end
    drive(0, 1'b0, 1'b0, BASE, '0, 4'h0);
    @(negedge clk);
  endtask

  task automatic test_write_read;
    int lat, lows;
    word_t rd, a;
    logic er;
    a = 32'h8000_0010;
    acc(0, 1'b0, 1'b1, a, 32'hDEAD_BEEF, 4'hF, lat, rd, er);
    mwrite(0, a, 32'hDEAD_BEEF, 4'hF);
    total++; if (lat !== 2) begin bad++; $display("FAIL wr_latency got %0d want 2", lat); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL wr_err got %b want 0", er); end
    acc(0, 1'b1, 1'b0, a, '0, 4'hF, lat, rd, er);
    total++; if (lat !== 2) begin bad++; $display("FAIL rd_latency got %0d want 2", lat); end
    total++; if (rd !== mread(0, a)) begin bad++; $display("FAIL rd_data got %h want %h", rd, mread(0, a)); end
    lows = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!b0.busy) lows++;
    end
    total++; if (lows !== 0) begin bad++; $display("FAIL extra_completion got %0d want 0", lows); end
  endtask

  task automatic test_byte_lanes;
    int lat;
    word_t rd, a;
    logic er;
    a = 32'h8000_0020;
    acc(0, 1'b0, 1'b1, a, 32'h1122_3344, 4'hF, lat, rd, er);
    mwrite(0, a, 32'h1122_3344, 4'hF);
    acc(0, 1'b0, 1'b1, a, 32'hAABB_CCDD, 4'b0101, lat, rd, er);
    mwrite(0, a, 32'hAABB_CCDD, 4'b0101);
    acc(0, 1'b1, 1'b0, a, '0, 4'h0, lat, rd, er);
    total++; if (rd !== mread(0, a)) begin bad++; $display("FAIL byte_lanes got %h want %h", rd, mread(0, a)); end
    acc(0, 1'b0, 1'b1, a, 32'hFFFF_FFFF, 4'h0, lat, rd, er);
    total++; if (lat !== 2 || er !== 1'b0) begin bad++; $display("FAIL be_zero_complete lat %0d err %b want 2 0", lat, er); end
    acc(0, 1'b1, 1'b0, a, '0, 4'h0, lat, rd, er);
    total++; if (rd !== mread(0, a)) begin bad++; $display("FAIL be_zero_nochange got %h want %h", rd, mread(0, a)); end
  endtask

  task automatic test_out_of_range;
    int lat;
    word_t rd, lo, hi, d;
    logic er;
    lo = BASE;
    hi = BASE + 4 * (D0 - 1);
    d = $urandom; acc(0, 1'b0, 1'b1, lo, d, 4'hF, lat, rd, er); mwrite(0, lo, d, 4'hF);
    d = $urandom; acc(0, 1'b0, 1'b1, hi, d, 4'hF, lat, rd, er); mwrite(0, hi, d, 4'hF);
    acc(0, 1'b1, 1'b0, 32'h7FFF_FFFC, '0, 4'hF, lat, rd, er);
    total++; if (rd !== ERRV) begin bad++; $display("FAIL oor_rdata got %h want %h", rd, ERRV); end
    total++; if (er !== 1'b1) begin bad++; $display("FAIL oor_rd_err got %b want 1", er); end
    acc(0, 1'b0, 1'b1, BASE + 4 * D0, 32'h0BAD_F00D, 4'hF, lat, rd, er);
    mwrite(0, BASE + 4 * D0, 32'h0BAD_F00D, 4'hF);
    total++; if (er !== 1'b1 || lat !== 2) begin bad++; $display("FAIL oor_wr err %b lat %0d want 1 2", er, lat); end
    acc(0, 1'b1, 1'b0, lo, '0, 4'hF, lat, rd, er);
    total++; if (rd !== mread(0, lo) || er !== 1'b0) begin bad++; $display("FAIL word0_kept got %h err %b want %h 0", rd, er, mread(0, lo)); end
    acc(0, 1'b1, 1'b0, hi, '0, 4'hF, lat, rd, er);
    total++; if (rd !== mread(0, hi)) begin bad++; $display("FAIL wordlast_kept got %h want %h", rd, mread(0, hi)); end
    acc(0, 1'b1, 1'b0, BASE + 4 * D0 - 1, '0, 4'hF, lat, rd, er);
    total++; if (rd !== mread(0, hi) || er !== 1'b0) begin bad++; $display("FAIL top_byte_hit got %h err %b want %h 0", rd, er, mread(0, hi)); end
    acc(0, 1'b1, 1'b1, BASE + 32'h800, 32'h1234_5678, 4'hF, lat, rd, er);
    m0.delete(widx(BASE + 32'h800));
    total++; if (er !== 1'b1 || lat !== 2) begin bad++; $display("FAIL ren_wen err %b lat %0d want 1 2", er, lat); end
  endtask

  task automatic test_wait_states;
    int lat, lows;
    word_t rd, a, d;
    logic er;
    a = BASE + 4 * 5;
    d = $urandom;
    acc(1, 1'b0, 1'b1, a, d, 4'hF, lat, rd, er);
    mwrite(1, a, d, 4'hF);
    total++; if (lat !== W1 + 2) begin bad++; $display("FAIL ws_wr_latency got %0d want %0d", lat, W1 + 2); end
    acc(1, 1'b1, 1'b0, a, '0, 4'hF, lat, rd, er);
    total++; if (lat !== W1 + 2) begin bad++; $display("FAIL ws_rd_latency got %0d want %0d", lat, W1 + 2); end
    total++; if (rd !== mread(1, a)) begin bad++; $display("FAIL ws_rd_data got %h want %h", rd, mread(1, a)); end
    drive(1, 1'b1, 1'b0, a, '0, 4'hF);
    lows = 0;
    for (int i = 0; i < 2; i++) begin @(negedge clk); if (!b1.busy) lows++; end
    drive(1, 1'b0, 1'b0, a, '0, 4'hF);
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (!b1.busy) lows++; end
    total++; if (lows !== 0) begin bad++; $display("FAIL withdraw_pulse got %0d want 0", lows); end
    acc(1, 1'b1, 1'b0, a, '0, 4'hF, lat, rd, er);
    total++; if (lat !== W1 + 2 || rd !== mread(1, a)) begin bad++; $display("FAIL after_withdraw lat %0d data %h want %0d %h", lat, rd, W1 + 2, mread(1, a)); end
    drive(1, 1'b0, 1'b1, a, ~d, 4'hF);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    drive(1, 1'b0, 1'b0, a, '0, 4'h0);
    total++; if (b1.busy !== 1'b1) begin bad++; $display("FAIL rst_abort_busy got %b want 1", b1.busy); end
    @(negedge clk);
    acc(1, 1'b1, 1'b0, a, '0, 4'hF, lat, rd, er);
    total++; if (rd !== mread(1, a)) begin bad++; $display("FAIL rst_abort_data got %h want %h", rd, mread(1, a)); end
    drive(1, 1'b0, 1'b1, a, d ^ 32'h5A5A_5A5A, 4'hF);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!b1.busy) begin lat = i; break; end
    end
    rst = 1;
    drive(1, 1'b0, 1'b0, a, '0, 4'h0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    total++; if (lat !== W1 + 2) begin bad++; $display("FAIL rst_commit_latency got %0d want %0d", lat, W1 + 2); end
    acc(1, 1'b1, 1'b0, a, '0, 4'hF, lat, rd, er);
    total++; if (rd !== mread(1, a)) begin bad++; $display("FAIL rst_commit_data got %h want %h", rd, mread(1, a)); end
  endtask

  task automatic test_random;
    int lat;
    word_t rd, a, d;
    byte_en_t be;
    logic er, w, hit;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      acc(0, 1'b0, 1'b1, BASE + 32'h200 + 4 * i, d, 4'hF, lat, rd, er);
      mwrite(0, BASE + 32'h200 + 4 * i, d, 4'hF);
    end
    for (int i = 0; i < 30; i++) begin
      a = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? BASE - 4 * $urandom_range(1, 8) : BASE + 4 * D0 + $urandom_range(0, 63))
                                      : BASE + 32'h200 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      d = $urandom;
      be = 4'($urandom_range(0, 15));
      w = 1'($urandom_range(0, 1));
      hit = in_rng(a, D0);
      acc(0, !w, w, a, d, be, lat, rd, er);
      total++; if (lat !== 2 || er !== !hit) begin bad++; $display("FAIL rand%0d a=%h lat %0d err %b want 2 %b", i, a, lat, er, !hit); end
      if (w) mwrite(0, a, d, be);
      else begin
        total++; if (rd !== mread(0, a)) begin bad++; $display("FAIL rand%0d_rd a=%h got %h want %h", i, a, rd, mread(0, a)); end
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, n, last;
    word_t rd, d, ab;
    logic er;
    ab = BASE + 32'h100;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      acc(0, 1'b0, 1'b1, ab + 4 * i, d, 4'hF, lat, rd, er);
      mwrite(0, ab + 4 * i, d, 4'hF);
    end
    drive(0, 1'b1, 1'b0, ab, '0, 4'hF);
    n = 0;
    last = 0;
    for (int c = 1; c <= 60 && n < 8; c++) begin
      @(negedge clk);
      if (!b0.busy) begin
        total++; if (b0.rdata !== mread(0, ab + 4 * n)) begin bad++; $display("FAIL b2b_data%0d got %h want %h", n, b0.rdata, mread(0, ab + 4 * n)); end
        total++; if (c - last !== (n == 0 ? 2 : 3)) begin bad++; $display("FAIL b2b_spacing%0d got %0d want %0d", n, c - last, n == 0 ? 2 : 3); end
        last = c;
        n++;
        b0.addr = ab + 4 * n;
      end
    end
    drive(0, 1'b0, 1'b0, ab, '0, 4'h0);
    total++; if (n !== 8) begin bad++; $display("FAIL b2b_count got %0d want 8", n); end
    @(negedge clk);
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, '0, '0, 4'h0);
    drive(1, 1'b0, 1'b0, '0, '0, 4'h0);
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_out_of_range();
    test_wait_states();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
